// File: rtl/axis_fifo_arb_pkg.sv
// Shared types and helpers for the axis_fifo_arb frame-granular round-robin arbiter.
package axis_fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DROP   = 2'd2
    } state_t;

    // Width of a source index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axis_fifo_arb_rr.sv
// Combinational round-robin selector: first requester at or above ptr, wrapping.
module axis_fifo_arb_rr
    import axis_fifo_arb_pkg::*;
#(
    parameter int S_COUNT = 4,
    parameter int IDX_W   = idx_width(S_COUNT)
) (
    input  logic [S_COUNT-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [S_COUNT-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    logic [IDX_W-1:0] cand [S_COUNT];

    // cand[k] is the port k positions after ptr, modulo S_COUNT.
    for (genvar gi = 0; gi < S_COUNT; gi++) begin : g_cand
        logic [IDX_W:0] sum;
        assign sum = {1'b0, ptr} + (IDX_W+1)'(gi);
        assign cand[gi] = (sum >= (IDX_W+1)'(S_COUNT)) ?
                          IDX_W'(sum - (IDX_W+1)'(S_COUNT)) : sum[IDX_W-1:0];
    end

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        // Scan from the farthest offset down so the nearest requester wins.
        for (int k = S_COUNT - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                idx   = cand[k];
                valid = 1'b1;
            end
        end
        grant[idx] = valid;
    end

endmodule

// File: rtl/axis_fifo_arb.sv
// Frame-granular round-robin arbiter feeding one AXI-stream FIFO write port.
// Optional stall timeout with frame termination: define AXIS_FIFO_ARB_TIMEOUT_EN.
module axis_fifo_arb
    import axis_fifo_arb_pkg::*;
#(
    parameter int S_COUNT    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 1,
    parameter int ID_WIDTH   = 8,
    parameter int TIMEOUT    = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_COUNT-1:0]            s_axis_tvalid,
    output logic [S_COUNT-1:0]            s_axis_tready,
    input  logic [S_COUNT-1:0]            s_axis_tlast,
    input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [ID_WIDTH-1:0]           m_axis_tid,
    output logic [USER_WIDTH-1:0]         m_axis_tuser,
    output logic [S_COUNT-1:0]            grant,
    output logic                          busy
);

    localparam int IDX_W = idx_width(S_COUNT);

    if (ID_WIDTH < IDX_W || S_COUNT < 2 || S_COUNT > 16 || TIMEOUT < 1) begin : g_bad_params
        $error("axis_fifo_arb: parameter out of range");
    end

    state_t                 state_reg;
    logic [IDX_W-1:0]       ptr_reg;
    logic [IDX_W-1:0]       sel_reg;
    logic [S_COUNT-1:0]     grant_reg;
    logic                   m_valid_reg;
    logic [DATA_WIDTH-1:0]  m_data_reg;
    logic                   m_last_reg;
    logic [ID_WIDTH-1:0]    m_id_reg;
    logic [USER_WIDTH-1:0]  m_user_reg;

    logic [S_COUNT-1:0]     rr_grant;
    logic [IDX_W-1:0]       rr_idx;
    logic                   rr_valid;

    logic [DATA_WIDTH-1:0]  data_arr [S_COUNT];
    logic [USER_WIDTH-1:0]  user_arr [S_COUNT];
    logic                   out_free;
    logic                   port_ready;
    logic                   sel_valid;
    logic                   sel_last;
    logic                   accept;
    logic                   stall_hit;
    logic [IDX_W-1:0]       ptr_next;

    axis_fifo_arb_rr #(
        .S_COUNT (S_COUNT),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req   (s_axis_tvalid),
        .ptr   (ptr_reg),
        .grant (rr_grant),
        .idx   (rr_idx),
        .valid (rr_valid)
    );

    for (genvar gi = 0; gi < S_COUNT; gi++) begin : g_port
        assign data_arr[gi]      = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
        assign user_arr[gi]      = s_axis_tuser[gi*USER_WIDTH +: USER_WIDTH];
        assign s_axis_tready[gi] = port_ready && (sel_reg == IDX_W'(gi));
    end

`ifdef AXIS_FIFO_ARB_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT + 1);
    logic [STALL_W-1:0] stall_reg;

    assign stall_hit = (stall_reg == STALL_W'(TIMEOUT));

    // Counts idle source cycles within a frame; any accepted beat or leaving ACTIVE restarts it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_reg <= '0;
        end else if (state_reg != ACTIVE || accept) begin
            stall_reg <= '0;
        end else if (!sel_valid && !stall_hit) begin
            stall_reg <= stall_reg + STALL_W'(1);
        end
    end

    assign port_ready = (state_reg == ACTIVE && out_free && !stall_hit) || (state_reg == DROP);
`else
    assign stall_hit  = 1'b0;
    assign port_ready = (state_reg == ACTIVE) && out_free && !stall_hit;
`endif

    assign out_free  = !m_valid_reg || m_axis_tready;
    assign sel_valid = s_axis_tvalid[sel_reg];
    assign sel_last  = s_axis_tlast[sel_reg];
    assign accept    = port_ready && sel_valid;
    assign ptr_next  = (sel_reg == IDX_W'(S_COUNT - 1)) ? '0 : sel_reg + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            sel_reg     <= '0;
            grant_reg   <= '0;
            m_valid_reg <= 1'b0;
            m_data_reg  <= '0;
            m_last_reg  <= 1'b0;
            m_id_reg    <= '0;
            m_user_reg  <= '0;
        end else begin
            // Drain the output register; a load below takes precedence.
            if (m_axis_tready) begin
                m_valid_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (rr_valid) begin
                        grant_reg <= rr_grant;
                        sel_reg   <= rr_idx;
                        state_reg <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (accept) begin
                        m_valid_reg <= 1'b1;
                        m_data_reg  <= data_arr[sel_reg];
                        m_last_reg  <= sel_last;
                        m_user_reg  <= user_arr[sel_reg];
                        m_id_reg    <= ID_WIDTH'(sel_reg);
                        if (sel_last) begin
                            ptr_reg   <= ptr_next;
                            grant_reg <= '0;
                            state_reg <= IDLE;
                        end
                    end else if (stall_hit && out_free) begin
                        // Close the frame downstream with a marked terminator beat.
                        m_valid_reg <= 1'b1;
                        m_data_reg  <= '0;
                        m_last_reg  <= 1'b1;
                        m_user_reg  <= {USER_WIDTH{1'b1}};
                        m_id_reg    <= ID_WIDTH'(sel_reg);
                        state_reg   <= DROP;
                    end
                end
`ifdef AXIS_FIFO_ARB_TIMEOUT_EN
                DROP: begin
                    if (accept && sel_last) begin
                        ptr_reg   <= ptr_next;
                        grant_reg <= '0;
                        state_reg <= IDLE;
                    end
                end
`endif
                default: begin
                    grant_reg <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign m_axis_tvalid = m_valid_reg;
    assign m_axis_tdata  = m_data_reg;
    assign m_axis_tlast  = m_last_reg;
    assign m_axis_tid    = m_id_reg;
    assign m_axis_tuser  = m_user_reg;
    assign grant         = grant_reg;
    assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_axis_fifo_arb.sv
// Self-checking bench for axis_fifo_arb: vector table, directed sequences and a randomized run.
`timescale 1ns/1ps
module tb_axis_fifo_arb;

    localparam int S  = 4;
    localparam int DW = 8;
    localparam int UW = 1;
    localparam int IW = 8;
`ifdef AXIS_FIFO_ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 256;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [S*DW-1:0] s_tdata  = '0;
    logic [S-1:0]    s_tvalid = '0;
    logic [S-1:0]    s_tready;
    logic [S-1:0]    s_tlast  = '0;
    logic [S*UW-1:0] s_tuser  = '0;
    logic [DW-1:0]   m_tdata;
    logic            m_tvalid;
    logic            m_tready = 1'b1;
    logic            m_tlast;
    logic [IW-1:0]   m_tid;
    logic [UW-1:0]   m_tuser;
    logic [S-1:0]    grant;
    logic            busy;

    always #5 clk = ~clk;

    axis_fifo_arb #(
        .S_COUNT(S), .DATA_WIDTH(DW), .USER_WIDTH(UW), .ID_WIDTH(IW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast), .m_axis_tid(m_tid), .m_axis_tuser(m_tuser),
        .grant(grant), .busy(busy)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic          last;
        int            gap;
    } beat_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic          last;
        int            tid;
    } obeat_t;

    typedef struct {
        logic [S-1:0]    v;
        logic [S*DW-1:0] d;
        logic [S-1:0]    l;
        logic [S-1:0]    st;
        logic            mv;
        logic [DW-1:0]   md;
        logic            ml;
        logic [IW-1:0]   id;
        logic [S-1:0]    g;
        logic            b;
    } vec_t;

    beat_t  src_q [S][$];
    int     gap_cnt [S];
    bit     loaded [S];
    obeat_t out_q[$];
    obeat_t exp_q[$];
    int     tests = 0;
    int     fails = 0;
    int     bp_viol = 0;
    int     model_ptr = 0;
    int     ready_mode = 0;
    int     in_acc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pack(input obeat_t b);
        return 64'({b.data, b.user, b.last, 8'(b.tid)});
    endfunction

    function automatic bit any_pending();
        for (int i = 0; i < S; i++) if (src_q[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    // Present each source's front beat, honouring its pre-beat gap, and set m_tready.
    task automatic drive();
        for (int i = 0; i < S; i++) begin
            if (src_q[i].size() > 0) begin
                if (!loaded[i]) begin
                    gap_cnt[i] = src_q[i][0].gap;
                    loaded[i]  = 1'b1;
                end
                if (gap_cnt[i] > 0) begin
                    s_tvalid[i] = 1'b0;
                    gap_cnt[i]--;
                end else begin
                    s_tvalid[i] = 1'b1;
                end
                s_tdata[i*DW +: DW] = src_q[i][0].data;
                s_tuser[i*UW +: UW] = src_q[i][0].user;
                s_tlast[i]          = src_q[i][0].last;
            end else begin
                s_tvalid[i] = 1'b0;
                s_tlast[i]  = 1'b0;
            end
        end
        case (ready_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            default: m_tready = ($urandom_range(0, 9) < 7);
        endcase
    endtask

    // One clock: sample handshakes mid-cycle, then retire accepted source beats.
    task automatic cycle();
        logic [S-1:0] acc;
        obeat_t ob;
        @(negedge clk);
        acc = s_tvalid & s_tready;
        if (m_tvalid && !m_tready && (s_tready != '0)) bp_viol++;
        if (m_tvalid && m_tready) begin
            ob.data = m_tdata; ob.user = m_tuser; ob.last = m_tlast; ob.tid = int'(m_tid);
            out_q.push_back(ob);
        end
        @(posedge clk); #1;
        for (int i = 0; i < S; i++) begin
            if (acc[i] && src_q[i].size() > 0) begin
                void'(src_q[i].pop_front());
                loaded[i] = 1'b0;
                in_acc++;
            end
        end
    endtask

    // Reference: whole frames leave in round-robin order over sources with pending frames.
    task automatic build_expected();
        beat_t  tmp [S][$];
        obeat_t ob;
        beat_t  b;
        int     pick;
        for (int i = 0; i < S; i++) tmp[i] = src_q[i];
        while (1) begin
            pick = -1;
            for (int k = 0; k < S; k++) begin
                if (pick < 0 && tmp[(model_ptr + k) % S].size() > 0) pick = (model_ptr + k) % S;
            end
            if (pick < 0) break;
            do begin
                b = tmp[pick].pop_front();
                ob.data = b.data; ob.user = b.user; ob.last = b.last; ob.tid = pick;
                exp_q.push_back(ob);
            end while (!b.last);
            model_ptr = (pick + 1) % S;
        end
    endtask

    task automatic gen_frame(input int src, input int len, input bit gaps);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = DW'($urandom);
            b.user = UW'($urandom);
            b.last = (k == len - 1);
            b.gap  = (k == 0 || !gaps) ? 0 :
                     (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
            src_q[src].push_back(b);
        end
    endtask

    task automatic add_beat(input int src, input logic [DW-1:0] d, input logic l, input int gap);
        beat_t b;
        b.data = d; b.user = '0; b.last = l; b.gap = gap;
        src_q[src].push_back(b);
    endtask

    task automatic add_exp(input logic [DW-1:0] d, input logic [UW-1:0] u, input logic l, input int tid);
        obeat_t ob;
        ob.data = d; ob.user = u; ob.last = l; ob.tid = tid;
        exp_q.push_back(ob);
    endtask

    task automatic run(input string name, input int budget, input bit use_model);
        int n;
        int cnt;
        n = 0;
        if (use_model) build_expected();
        while ((any_pending() || out_q.size() < exp_q.size() || m_tvalid) && n < budget) begin
            drive();
            cycle();
            n++;
        end
        drive();
        if (n >= budget) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s_budget: ran %0d cycles, required completion within %0d", name, n, budget);
        end
        check({name, "_count"}, 64'(out_q.size()), 64'(exp_q.size()));
        cnt = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
        for (int k = 0; k < cnt; k++) begin
            $display("[TB] %s beat %0d tid=%0d data=%02h user=%0h last=%0d",
                     name, k, out_q[k].tid, out_q[k].data, out_q[k].user, out_q[k].last);
            check($sformatf("%s_beat%0d", name, k), pack(out_q[k]), pack(exp_q[k]));
        end
        out_q.delete();
        exp_q.delete();
    endtask

    task automatic clear_sources();
        for (int i = 0; i < S; i++) begin
            src_q[i].delete();
            loaded[i] = 1'b0;
        end
        s_tvalid = '0;
        s_tlast  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_sources();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_ptr = 0;
        out_q.delete();
    endtask

    vec_t vecs [6];
    logic [63:0] act_v;
    logic [63:0] exp_v;

    initial begin
        // Port 2 sends 0x11,0x22,0x33 with the FIFO always ready.
        vecs[0] = '{4'b0100, 32'h0011_0000, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 8'd0, 4'b0000, 1'b0};
        vecs[1] = '{4'b0100, 32'h0011_0000, 4'b0000, 4'b0100, 1'b0, 8'h00, 1'b0, 8'd0, 4'b0100, 1'b1};
        vecs[2] = '{4'b0100, 32'h0022_0000, 4'b0000, 4'b0100, 1'b1, 8'h11, 1'b0, 8'd2, 4'b0100, 1'b1};
        vecs[3] = '{4'b0100, 32'h0033_0000, 4'b0100, 4'b0100, 1'b1, 8'h22, 1'b0, 8'd2, 4'b0100, 1'b1};
        vecs[4] = '{4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 1'b1, 8'h33, 1'b1, 8'd2, 4'b0000, 1'b0};
        vecs[5] = '{4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 8'd0, 4'b0000, 1'b0};

        // Reset state, observed while reset is still held.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_m_payload", 64'({m_tdata, m_tlast, m_tid, m_tuser}), 64'd0);
        check("rst_s_tready", 64'(s_tready), 64'd0);
        check("rst_grant_busy", 64'({grant, busy}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        model_ptr = 0;

        // Ports 0 and 1 contend with two 2-beat frames each: expect 0,1,0,1.
        ready_mode = 0;
        for (int f = 0; f < 2; f++) begin
            gen_frame(0, 2, 1'b0);
            gen_frame(1, 2, 1'b0);
        end
        run("alternate", 200, 1'b1);

        // Cycle-by-cycle vector table for a lone 3-beat frame on port 2.
        for (int r = 0; r < 6; r++) begin
            s_tvalid = vecs[r].v;
            s_tdata  = vecs[r].d;
            s_tlast  = vecs[r].l;
            s_tuser  = 4'b0100;
            m_tready = 1'b1;
            @(negedge clk);
            act_v = 64'({s_tready, m_tvalid,
                         m_tvalid ? m_tdata : 8'h00, m_tvalid ? m_tlast : 1'b0,
                         m_tvalid ? m_tid : 8'd0, m_tvalid ? m_tuser : 1'b0, grant, busy});
            exp_v = 64'({vecs[r].st, vecs[r].mv, vecs[r].md, vecs[r].ml, vecs[r].id,
                         vecs[r].mv, vecs[r].g, vecs[r].b});
            $display("[TB] vec %0d s_tready=%b m_tvalid=%0d data=%02h grant=%b busy=%0d",
                     r, s_tready, m_tvalid, m_tdata, grant, busy);
            check($sformatf("vec%0d", r), act_v, exp_v);
            @(posedge clk); #1;
        end
        s_tuser = '0;
        model_ptr = 3;  // the port 2 frame just completed

        // Wrap-around: pointer at 3, ports 0 and 3 requesting -> 3 then 0.
        gen_frame(0, 2, 1'b0);
        gen_frame(3, 3, 1'b0);
        run("wrap", 200, 1'b1);

        // Back-pressure toggling during a 4-beat frame.
        ready_mode = 1;
        m_tready = 1'b0;
        bp_viol = 0;
        gen_frame(1, 4, 1'b0);
        run("toggle", 200, 1'b1);
        check("toggle_backpressure", 64'(bp_viol), 64'd0);

        // Reset after two beats of a 5-beat frame from port 0.
        ready_mode = 0;
        in_acc = 0;
        gen_frame(0, 5, 1'b0);
        for (int n = 0; n < 20 && in_acc < 2; n++) begin
            drive();
            cycle();
        end
        check("midrst_two_beats", 64'(in_acc), 64'd2);
        rst = 1'b0;
        clear_sources();
        cycle();
        check("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("midrst_grant_busy", 64'({grant, busy}), 64'd0);
        rst = 1'b1;
        out_q.delete();
        model_ptr = 0;
        gen_frame(1, 3, 1'b0);
        run("after_rst", 200, 1'b1);

        // Randomized traffic on all ports with source gaps and random FIFO stalls.
        ready_mode = 2;
        bp_viol = 0;
        for (int i = 0; i < S; i++) begin
            for (int f = 0; f < 3; f++) gen_frame(i, int'($urandom_range(1, 4)), 1'b1);
        end
        run("random", 3000, 1'b1);
        check("random_backpressure", 64'(bp_viol), 64'd0);

`ifdef AXIS_FIFO_ARB_TIMEOUT_EN
        // Port 0 stalls after its first beat; the frame is terminated and the rest dropped.
        ready_mode = 0;
        do_reset();
        add_beat(0, 8'hA1, 1'b0, 0);
        add_beat(0, 8'hA2, 1'b0, 12);
        add_beat(0, 8'hA3, 1'b1, 0);
        add_beat(1, 8'hB1, 1'b0, 0);
        add_beat(1, 8'hB2, 1'b1, 0);
        add_exp(8'hA1, 1'b0, 1'b0, 0);
        add_exp(8'h00, 1'b1, 1'b1, 0);
        add_exp(8'hB1, 1'b0, 1'b0, 1);
        add_exp(8'hB2, 1'b0, 1'b1, 1);
        run("timeout", 300, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
